isp_pattern_gen: RTL
====================

Name: isp_pattern_gen

Overview:
- Video stream source driving the ISP pixel interface: vsync/hsync/den plus 8-bit R/G/B, the same signalling consumed by the AWB stage and other RGB-domain ISP blocks.
- Generates programmable frame timing and selectable test patterns.
- Used as the bring-up/verification stimulus source and as a fallback source when the sensor path is down.
- Sits at the head of the RGB pipeline, clocked with the pixel clock.

Parameters:
H_ACTIVE, 1024, active pixels per line (multiple of 8, >=8)
H_BLANK, 64, horizontal blanking cycles per line (>=1)
V_ACTIVE, 1024, active lines per frame (>=1)
V_BLANK, 8, blanking lines before each frame's active region (>=1)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run request; level-sensitive
pattern_sel  in  2  0 solid, 1 colour bars, 2 gray ramp, 3 checkerboard
solid_R  in  8  solid-colour red value
solid_G  in  8  solid-colour green value
solid_B  in  8  solid-colour blue value
out_vsync  out  1  high for the whole active region of a frame (all V_ACTIVE lines, including their h-blank)
out_hsync  out  1  high during active pixels of an active line
out_den  out  1  pixel valid; identical to out_hsync
out_data_R  out  8  red pixel
out_data_G  out  8  green pixel
out_data_B  out  8  blue pixel
frame_done  out  1  one-cycle pulse in the cycle out_vsync falls
frame_cnt  out  16  completed-frame counter, wraps at 65535->0
busy  out  1  high when the FSM is not IDLE

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; counters clear. Reset takes effect immediately, including mid-frame. No partial-frame completion and no frame_done pulse.
- All outputs are registered. Data and syncs are aligned in the same cycle.
- H_TOTAL = H_ACTIVE + H_BLANK.
- Counters:
  - x counts 0..H_TOTAL-1.
  - y counts lines within the current state.
- FSM states: IDLE, VBLANK, ACTIVE.
- IDLE:
  - All syncs and data are 0; busy=0.
  - enable=1 sampled at a clock edge moves the FSM to VBLANK with x=y=0.
- VBLANK:
  - Runs V_BLANK*H_TOTAL cycles with vsync=hsync=den=0 and data=0.
  - Then goes to ACTIVE with x=y=0.
- ACTIVE:
  - out_vsync=1 for the full V_ACTIVE*H_TOTAL cycles.
  - Per line: H_ACTIVE cycles with hsync=den=1 and valid data, then H_BLANK cycles with hsync=den=0 and data=0.
- End of the last ACTIVE line:
  - Next cycle: out_vsync=0, frame_done=1, frame_cnt increments.
  - If enable=1 in that final cycle, go to VBLANK; otherwise go to IDLE.
- enable deasserted mid-frame (VBLANK or ACTIVE): the current frame always completes. enable is only evaluated at IDLE and at end of frame.
- pattern_sel and solid_R/G/B are latched on the IDLE->VBLANK and ACTIVE->VBLANK transitions. Changes mid-frame have no effect until the next frame.
- Patterns, with x = active pixel index 0..H_ACTIVE-1 and y = active line index:
  - 0 solid: latched solid_R/G/B.
  - 1 colour bars: bar = x / (H_ACTIVE/8). Implement with a bar-width counter, not a divider. Bars 0..7 are white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - 2 gray ramp: R=G=B=x[7:0]; wraps every 256 pixels.
  - 3 checkerboard: 32x32 cells. White when x[5]^y[5]=0, else black.
- Frame timing is guaranteed back-to-back: with enable held at 1, frame period = (V_BLANK+V_ACTIVE)*H_TOTAL cycles exactly.

Decomposition:
- Shared package isp_pkg:
  - pattern_sel encodings (PAT_SOLID=0, PAT_BARS=1, PAT_RAMP=2, PAT_CHECK=3)
  - the 8-entry colour-bar RGB constant table
  - FSM state encoding
- One sub-module, isp_pattern_pix: combinational pixel colour from (pattern, x, y, bar index, solid colour).
- The top-level module holds the FSM, counters and output registers.

Test Plan (H_ACTIVE=16, H_BLANK=4, V_ACTIVE=4, V_BLANK=2):
1. Reset held, enable=1 -> all outputs 0, busy=0. Release reset, enable=1 -> out_vsync first rises exactly 1+2*20 cycles after the enable-sampling edge. Per frame: 4 hsync pulses of 16 cycles, separated by 4-cycle gaps.
2. pattern_sel=1 -> each line shows pixels 0-1 FFFFFF, 2-3 FFFF00, ..., 14-15 000000. Data is 0 during h-blank and VBLANK.
3. enable=1 for 3 frames -> frame_done pulses 120 cycles apart; frame_cnt = 1, 2, 3. Drop enable during frame 3's ACTIVE state -> frame 3 completes, then IDLE, busy=0.
4. pattern_sel=0, solid=12/34/56; change solid to AA/BB/CC mid-ACTIVE -> remainder of the frame stays 12/34/56, next frame is AA/BB/CC.
5. Assert reset mid-ACTIVE line -> all outputs 0 asynchronously, with no frame_done pulse. After release with enable=1, timing restarts from VBLANK.
6. pattern_sel=2 and 3 -> ramp data equals x (0..15). Checkerboard is all FFFFFF, since x,y<32. Force frame_cnt to wrap by preloading it to 65535 in the bench -> next completed frame gives 0.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared definitions for the ISP test-pattern source: pattern encodings,
// FSM state encoding and the colour-bar palette.
package isp_pkg;

    // Packed RGB pixel, {R, G, B}
    typedef logic [23:0] rgb_t;

    // pattern_sel encodings
    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_RAMP  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    // Frame FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VBLANK = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    // Colour bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam rgb_t BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/isp_pattern_pix.sv
// Combinational pixel colour for the selected test pattern at one pixel position.
module isp_pattern_pix
    import isp_pkg::*;
(
    input  logic [1:0]  pattern_i,
    input  logic [7:0]  x_i,       // active pixel index, low byte
    input  logic        y5_i,      // bit 5 of the active line index
    input  logic [2:0]  bar_i,     // colour-bar index for this pixel
    input  logic [23:0] solid_i,   // {R, G, B}
    output logic [23:0] pix_o      // {R, G, B}
);

    // Select the colour of the current pixel from the latched pattern.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        pix_o = '0;
        case (pattern_i)
            PAT_SOLID: pix_o = solid_i;
            PAT_BARS:  pix_o = BAR_RGB[bar_i];
            PAT_RAMP:  pix_o = {3{x_i}};
            PAT_CHECK: pix_o = (x_i[5] ^ y5_i) ? 24'h000000 : 24'hFFFFFF;
            default:   pix_o = '0;
        endcase
    end

endmodule

// File: rtl/isp_pattern_gen.sv
// Programmable-timing test-pattern source for the RGB ISP pipeline.
// Frame = V_BLANK blank lines followed by V_ACTIVE active lines, each line
// H_ACTIVE pixels plus H_BLANK blank cycles. All outputs are registered one
// cycle behind the timing FSM so syncs and data stay aligned.
module isp_pattern_gen
    import isp_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int H_BLANK  = 64,
    parameter int V_ACTIVE = 1024,
    parameter int V_BLANK  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [7:0]  solid_R,
    input  logic [7:0]  solid_G,
    input  logic [7:0]  solid_B,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic        out_den,
    output logic [7:0]  out_data_R,
    output logic [7:0]  out_data_G,
    output logic [7:0]  out_data_B,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int V_MAX   = (V_ACTIVE > V_BLANK) ? V_ACTIVE : V_BLANK;
    localparam int YW      = $clog2(V_MAX + 1);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] VB_LAST  = YW'(V_BLANK - 1);
    localparam logic [YW-1:0] VA_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] Y_BIT5   = YW'(32);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    pat_q;
    logic [23:0]   solid_q;
    logic          latch_cfg;

    logic          out_vsync_q, out_hsync_q, frame_done_q, busy_q;
    logic [23:0]   out_data_q;
    logic [15:0]   frame_cnt_q;

    logic          line_end, active_px, frame_done_d, y5;
    logic [23:0]   pix;

    assign line_end     = (x_q == X_LAST);
    assign active_px    = (state_q == ST_ACTIVE) && (x_q < X_ACT);
    // vsync is still high but the FSM has already left ACTIVE: the frame just ended
    assign frame_done_d = out_vsync_q && (state_q != ST_ACTIVE);
    assign y5           = |(y_q & Y_BIT5);

    // Frame FSM and raster counters; enable is only looked at in IDLE and at end of frame.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        latch_cfg = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_VBLANK;
                    x_d       = '0;
                    y_d       = '0;
                    latch_cfg = 1'b1;
                end
            end
            ST_VBLANK: begin
                if (!line_end) begin
                    x_d = x_q + XW'(1);
                end else begin
                    x_d = '0;
                    if (y_q == VB_LAST) begin
                        state_d = ST_ACTIVE;
                        y_d     = '0;
                    end else begin
                        y_d = y_q + YW'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                if (!line_end) begin
                    x_d = x_q + XW'(1);
                end else begin
                    x_d = '0;
                    if (y_q == VA_LAST) begin
                        y_d       = '0;
                        state_d   = enable ? ST_VBLANK : ST_IDLE;
                        latch_cfg = enable;
                    end else begin
                        y_d = y_q + YW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = '0;
                y_d     = '0;
            end
        endcase
    end

    // Colour-bar position tracked by a bar-width counter instead of dividing x.
    always_comb begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (active_px) begin
            if (bar_cnt_q == BAR_LAST) begin
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + BW'(1);
                bar_idx_d = bar_idx_q;
            end
        end
    end

    // Timing state registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Pattern configuration is frozen at frame start so mid-frame changes wait for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q   <= PAT_SOLID;
            solid_q <= '0;
        end else if (latch_cfg) begin
            pat_q   <= pattern_sel;
            solid_q <= {solid_R, solid_G, solid_B};
        end
    end

    isp_pattern_pix u_pix (
        .pattern_i (pat_q),
        .x_i       (8'(x_q)),
        .y5_i      (y5),
        .bar_i     (bar_idx_q),
        .solid_i   (solid_q),
        .pix_o     (pix)
    );

    // Output registers: syncs, data and status all derived from the same FSM cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vsync_q  <= 1'b0;
            out_hsync_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            out_vsync_q  <= (state_q == ST_ACTIVE);
            out_hsync_q  <= active_px;
            out_data_q   <= active_px ? pix : 24'h0;
            frame_done_q <= frame_done_d;
            busy_q       <= (state_q != ST_IDLE);
            if (frame_done_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign out_vsync  = out_vsync_q;
    assign out_hsync  = out_hsync_q;
    assign out_den    = out_hsync_q;
    assign out_data_R = out_data_q[23:16];
    assign out_data_G = out_data_q[15:8];
    assign out_data_B = out_data_q[7:0];
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = busy_q;

endmodule
